// File: rtl/bd_tag_merge_pkg.sv
// BDTagMergePkg: widths, leaf code, source indices and word types shared by the tag merge block.
package BDTagMergePkg;
    localparam int NBDdata_out = 34;
    localparam int Nglobal = 12;
    localparam int Ntag = 11;
    localparam int Nct = 9;
    localparam int Ncount = 16;
    localparam int Nleaf = 4;
    localparam int Nword = NBDdata_out + Nleaf;
    localparam logic [Nleaf-1:0] INPUT_TAGS_code = 4'd2;

    typedef enum logic [1:0] {SRC_OTHER, SRC_TAG, SRC_GLOBAL} src_e;

    typedef struct packed {
        logic [NBDdata_out-1:0] payload;
        logic [Nleaf-1:0]       leaf_code;
    } word_t;

    typedef struct packed {
        logic global_en;
    } merge_conf_t;

    function automatic logic [1:0] wrap3(input logic [2:0] x);
        return (x >= 3'd3) ? 2'(x - 3'd3) : x[1:0];
    endfunction
endpackage

// File: rtl/bd_tag_merge_if.sv
// bd_tag_merge_if: valid/ack channel carrying a W-bit word.
interface bd_tag_merge_if #(parameter int W = 1);
    logic [W-1:0] d;
    logic         v;
    logic         a;
    modport master(output d, output v, input a);
    modport slave(input d, input v, output a);
endinterface

// File: rtl/bd_word_fifo2.sv
// bd_word_fifo2: 2-entry valid/ack word FIFO with a registered head; push is refused only when full.
module bd_word_fifo2
    import BDTagMergePkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  word_t din_i,
    output logic full_o,
    bd_tag_merge_if.master out_o
);
    word_t head_q, head_d, tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;
    logic push, pop;

    always_comb begin
        push = push_i & (cnt_q != 2'd2);
        pop = out_o.v & out_o.a;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
        head_d = head_q;
        tail_d = tail_q;
        // Popping a single entry while pushing lets the new word go straight to the head.
        if (pop) head_d = cnt_q[1] ? tail_q : din_i;
        else if (push && cnt_q == 2'd0) head_d = din_i;
        if (push && !pop && cnt_q == 2'd1) tail_d = din_i;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign full_o = cnt_q[1];
    assign out_o.v = (cnt_q != 2'd0);
    assign out_o.d = head_q;
endmodule

// File: rtl/bd_tag_merge.sv
// bd_tag_merge: round-robin merge of local tags, router global tags and other BD words into one stream.
module bd_tag_merge
    import BDTagMergePkg::*;
(
    input  logic clk,
    input  logic reset,
    bd_tag_merge_if.slave  tag_in,
    bd_tag_merge_if.slave  global_tag_in,
    bd_tag_merge_if.slave  other_in,
    bd_tag_merge_if.master BD_out,
    input  merge_conf_t conf,
    output logic [Ncount-1:0] tags_merged,
    output logic [Ncount-1:0] globals_dropped
);
    logic [1:0] ptr_q, ptr_d, idx;
    logic [2:0] req;
    logic [Ntag+Nct-1:0] tct;
    logic [Ncount-1:0] tm_q, tm_d, gd_q, gd_d;
    logic any, push, full, run, tag_hit, drop;
    src_e sel;
    word_t din, tag_word;

    always_comb begin
        run = reset;
        req = {conf.global_en & global_tag_in.v, tag_in.v, other_in.v};
        sel = SRC_OTHER;
        any = 1'b0;
        idx = '0;
        // Scan from furthest to nearest so the first requester at or after ptr wins.
        for (int i = 2; i >= 0; i--) begin
            idx = wrap3({1'b0, ptr_q} + 3'(i));
            if (req[idx]) begin
                sel = src_e'(idx);
                any = 1'b1;
            end
        end
        push = run & any & ~full;
        other_in.a = push & (sel == SRC_OTHER);
        tag_in.a = push & (sel == SRC_TAG);
        global_tag_in.a = run & (conf.global_en ? push & (sel == SRC_GLOBAL) : global_tag_in.v);
        ptr_d = push ? wrap3({1'b0, sel} + 3'd1) : ptr_q;
        tct = (sel == SRC_TAG) ? tag_in.d : global_tag_in.d[Ntag+Nct-1:0];
        tag_word.payload = NBDdata_out'(tct);
        tag_word.leaf_code = INPUT_TAGS_code;
        din = (sel == SRC_OTHER) ? word_t'(other_in.d) : tag_word;
        tag_hit = tag_in.a | (global_tag_in.a & conf.global_en);
        drop = global_tag_in.a & ~conf.global_en;
        tm_d = (tag_hit && tm_q != '1) ? tm_q + Ncount'(1) : tm_q;
        gd_d = (drop && gd_q != '1) ? gd_q + Ncount'(1) : gd_q;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ptr_q <= '0;
            tm_q <= '0;
            gd_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            tm_q <= tm_d;
            gd_q <= gd_d;
        end

    bd_word_fifo2 u_fifo (
        .clk(clk),
        .rst_n(reset),
        .push_i(push),
        .din_i(din),
        .full_o(full),
        .out_o(BD_out)
    );

    assign tags_merged = tm_q;
    assign globals_dropped = gd_q;
endmodule

// File: tb/tb_bd_tag_merge.sv
// tb_bd_tag_merge: scoreboard bench for bd_tag_merge; accepted words are queued and matched at BD_out.
module tb_bd_tag_merge;
    import BDTagMergePkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bd_tag_merge_if #(Ntag+Nct) tag_if();
    bd_tag_merge_if #(Nglobal+Ntag+Nct) glob_if();
    bd_tag_merge_if #(Nword) oth_if();
    bd_tag_merge_if #(Nword) out_if();
    merge_conf_t conf;
    logic [Ncount-1:0] tags_merged, globals_dropped;

    bd_tag_merge dut (
        .clk(clk),
        .reset(reset),
        .tag_in(tag_if),
        .global_tag_in(glob_if),
        .other_in(oth_if),
        .BD_out(out_if),
        .conf(conf),
        .tags_merged(tags_merged),
        .globals_dropped(globals_dropped)
    );

    int errors = 0;
    int checks = 0;
    logic [Nword-1:0] exp_q[$];
    logic [Nword-1:0] e;

    // Output side is compared before this cycle's accepted inputs are queued.
    always @(negedge clk) if (reset) begin
        if (out_if.v && out_if.a) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got=%h", out_if.d);
            end else begin
                e = exp_q.pop_front();
                if (out_if.d !== e) begin
                    errors++;
                    $display("FAIL out_word got=%h exp=%h", out_if.d, e);
                end
            end
        end
        if (oth_if.v && oth_if.a) exp_q.push_back(oth_if.d);
        if (tag_if.v && tag_if.a) exp_q.push_back({14'b0, tag_if.d, 4'd2});
        if (glob_if.v && glob_if.a && conf.global_en) exp_q.push_back({14'b0, glob_if.d[19:0], 4'd2});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        oth_if.v = 1'b0;
        tag_if.v = 1'b0;
        glob_if.v = 1'b0;
        out_if.a = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        conf.global_en = 1'b0;
        oth_if.d = '0;
        tag_if.d = '0;
        glob_if.d = '0;
        oth_if.v = 1'b1;
        tag_if.v = 1'b1;
        glob_if.v = 1'b1;
        out_if.a = 1'b1;
        #1;
        checks++;
        if ({glob_if.a, tag_if.a, oth_if.a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_acks got=%b exp=000", {glob_if.a, tag_if.a, oth_if.a});
        end
        checks++;
        if (out_if.v !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_v got=%b exp=0", out_if.v);
        end
        checks++;
        if (tags_merged !== 16'd0 || globals_dropped !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", tags_merged, globals_dropped);
        end
        reset_dut();
    endtask

    task automatic test_single_tag();
        out_if.a = 1'b0;
        conf.global_en = 1'b1;
        tag_if.d = {11'h155, 9'h00A};
        tag_if.v = 1'b1;
        #1;
        checks++;
        if (tag_if.a !== 1'b1) begin
            errors++;
            $display("FAIL single_tag_ack got=%b exp=1", tag_if.a);
        end
        cyc();
        tag_if.v = 1'b0;
        #1;
        checks++;
        if (out_if.v !== 1'b1 || out_if.d !== {34'h0_0002_AA0A, 4'd2}) begin
            errors++;
            $display("FAIL single_tag_word got=%b/%h exp=1/%h", out_if.v, out_if.d, {34'h0_0002_AA0A, 4'd2});
        end
        checks++;
        if (tags_merged !== 16'd1) begin
            errors++;
            $display("FAIL single_tag_count got=%0d exp=1", tags_merged);
        end
        out_if.a = 1'b1;
        cyc();
        checks++;
        if (out_if.v !== 1'b0) begin
            errors++;
            $display("FAIL single_tag_drain got=%b exp=0", out_if.v);
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        conf.global_en = 1'b1;
        out_if.a = 1'b1;
        oth_if.d = {34'h1_2345_6789, 4'd5};
        tag_if.d = {11'h7FF, 9'h1FF};
        glob_if.d = {12'h7FF, 11'h001, 9'h003};
        oth_if.v = 1'b1;
        tag_if.v = 1'b1;
        glob_if.v = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({glob_if.a, tag_if.a, oth_if.a} !== 3'(1 << (i % 3))) begin
                errors++;
                $display("FAIL rr_grant cycle=%0d got=%b exp=%b", i, {glob_if.a, tag_if.a, oth_if.a}, 3'(1 << (i % 3)));
            end
            if (i > 0) begin
                checks++;
                if (out_if.v !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_throughput cycle=%0d got=%b exp=1", i, out_if.v);
                end
            end
            if (i == 3) begin
                checks++;
                if (out_if.d !== {34'h203, 4'd2}) begin
                    errors++;
                    $display("FAIL rr_global_word got=%h exp=%h", out_if.d, {34'h203, 4'd2});
                end
            end
            cyc();
        end
        oth_if.v = 1'b0;
        tag_if.v = 1'b0;
        glob_if.v = 1'b0;
        cyc();
        cyc();
        checks++;
        if (tags_merged !== 16'd4) begin
            errors++;
            $display("FAIL rr_tag_count got=%0d exp=4", tags_merged);
        end
    endtask

    task automatic test_discard();
        reset_dut();
        conf.global_en = 1'b0;
        out_if.a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            glob_if.d = {12'(i + 1), 11'(i), 9'(i)};
            glob_if.v = 1'b1;
            #1;
            checks++;
            if (glob_if.a !== 1'b1 || out_if.v !== 1'b0) begin
                errors++;
                $display("FAIL discard cycle=%0d got a=%b v=%b exp a=1 v=0", i, glob_if.a, out_if.v);
            end
            cyc();
        end
        glob_if.v = 1'b0;
        #1;
        checks++;
        if (globals_dropped !== 16'd5 || tags_merged !== 16'd0) begin
            errors++;
            $display("FAIL discard_counts got=%0d/%0d exp=5/0", globals_dropped, tags_merged);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] p;
        logic acked;
        reset_dut();
        p = 34'h100;
        out_if.a = 1'b0;
        conf.global_en = 1'b0;
        glob_if.d = {12'hABC, 11'h123, 9'h045};
        glob_if.v = 1'b1;
        oth_if.d = {p, 4'd9};
        oth_if.v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (oth_if.a !== (i < 2) || glob_if.a !== 1'b1) begin
                errors++;
                $display("FAIL bp_stall cycle=%0d got a=%b g=%b exp a=%b g=1", i, oth_if.a, glob_if.a, i < 2);
            end
            acked = oth_if.a;
            cyc();
            if (acked) begin
                p = p + 34'd1;
                oth_if.d = {p, 4'd9};
            end
        end
        glob_if.v = 1'b0;
        out_if.a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (oth_if.a !== (i != 0) || out_if.v !== 1'b1) begin
                errors++;
                $display("FAIL bp_resume cycle=%0d got a=%b v=%b exp a=%b v=1", i, oth_if.a, out_if.v, i != 0);
            end
            acked = oth_if.a;
            cyc();
            if (acked) begin
                p = p + 34'd1;
                oth_if.d = {p, 4'd9};
            end
        end
        oth_if.v = 1'b0;
        cyc();
        cyc();
        checks++;
        if (out_if.v !== 1'b0 || exp_q.size() != 0 || globals_dropped !== 16'd4) begin
            errors++;
            $display("FAIL bp_drain got v=%b pending=%0d dropped=%0d exp v=0 pending=0 dropped=4", out_if.v, exp_q.size(), globals_dropped);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        conf.global_en = 1'b1;
        out_if.a = 1'b0;
        tag_if.d = {11'h0AA, 9'h055};
        tag_if.v = 1'b1;
        cyc();
        cyc();
        #1;
        checks++;
        if (out_if.v !== 1'b1 || tag_if.a !== 1'b0 || tags_merged !== 16'd2) begin
            errors++;
            $display("FAIL mid_full got v=%b a=%b cnt=%0d exp v=1 a=0 cnt=2", out_if.v, tag_if.a, tags_merged);
        end
        tag_if.v = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (out_if.v !== 1'b0 || tags_merged !== 16'd0 || globals_dropped !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%b cnt=%0d/%0d exp v=0 cnt=0/0", out_if.v, tags_merged, globals_dropped);
        end
        cyc();
        reset = 1'b1;
        oth_if.d = {34'h2_0000_0001, 4'd1};
        oth_if.v = 1'b1;
        tag_if.v = 1'b1;
        glob_if.v = 1'b1;
        #1;
        checks++;
        if ({glob_if.a, tag_if.a, oth_if.a} !== 3'b001) begin
            errors++;
            $display("FAIL mid_first_grant got=%b exp=001", {glob_if.a, tag_if.a, oth_if.a});
        end
        out_if.a = 1'b1;
        cyc();
        oth_if.v = 1'b0;
        tag_if.v = 1'b0;
        glob_if.v = 1'b0;
        cyc();
        cyc();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_tag();
        test_round_robin();
        test_discard();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bd_tag_merge.md
# bd_tag_merge

Merges the three BD-bound word sources into the single decoded word stream that feeds the BD encoder:
- locally generated tags;
- global tags returned from the router for this chip;
- all other downstream words (config, memory programming).

It is the inbound counterpart of the BD tag splitter. Tag sources are re-encoded as `INPUT_TAGS` leaf words with the global-tag field cleared. A fair round-robin arbiter and a 2-entry output buffer sustain one word per cycle.

## Interface
Parameters
- `NBDdata_out`, 34, payload width of decoded BD words
- `Nglobal`, 12, global tag field width
- `Ntag`, 11, tag field width
- `Nct`, 9, count field width
- `INPUT_TAGS_code`, 2, leaf code stamped on tag words
- `Ncount`, 16, status counter width

Ports
- `clk`  input  1  clock; single clock domain
- `reset`  input  1  asynchronous, active-low reset
- `tag_in`  TagCtChannel (sink)  `Ntag+Nct`  local tags, valid/ack
- `global_tag_in`  GlobalTagCtChannel (sink)  `Nglobal+Ntag+Nct`  tags returned by the router
- `other_in`  DecodedBDWordChannel (sink)  `NBDdata_out`+leaf code  non-tag words, passed through unchanged
- `BD_out`  DecodedBDWordChannel (source)  `NBDdata_out`+leaf code  merged stream to the encoder
- `conf`  TagMergeConf  1  `global_en`: 1 = merge global tags, 0 = discard them
- `tags_merged`  output  `Ncount`  saturating count of tag words accepted from `tag_in` and `global_tag_in`
- `globals_dropped`  output  `Ncount`  saturating count of global tags discarded

## Operation
- **Handshake.** A word transfers in any cycle where an input has `v=1` and its `a=1`. Sources hold `v` and payload until acked. `a` is combinational from the internal state and the input `v` signals.
- **Buffer.**
  - 2-entry FIFO, `cnt` ∈ {0,1,2}.
  - Push is allowed only when `cnt<2`. It does not depend on `BD_out.a`.
  - `BD_out.v = (cnt!=0)`. Payload and leaf code come from the head entry.
  - Pop when `BD_out.v & BD_out.a`.
  - Simultaneous push and pop leaves `cnt` unchanged.
- **Arbitration.**
  - Sources are indexed other=0, tag=1, global=2.
  - 2-bit pointer `ptr`, reset to 0.
  - Among requesters, grant the first at or after `ptr` in cyclic order.
  - On a grant to source k, `ptr ← (k+1) mod 3`. With no grant, `ptr` holds.
  - At most one grant per cycle. The granted input's `a=1` only if push is allowed.
  - `global_tag_in` requests only when `conf.global_en=1`.
- **Encoding.**
  - tag: payload = `{(NBDdata_out-Ntag-Nct)'0, tag, ct}`, leaf = `INPUT_TAGS_code`.
  - global: same format. The global tag field is zeroed, so `global_tag` is dropped.
  - other: payload and leaf copied unchanged.
- **Discard.** When `conf.global_en=0`:
  - `global_tag_in.a = global_tag_in.v` every cycle, independent of the FIFO and the arbiter.
  - `globals_dropped` increments per discarded word.
- **Counters.**
  - Each counter increments by at most 1 per cycle.
  - `tags_merged` increments on acceptance from `tag_in` or from merged `global_tag_in`.
  - Both counters saturate at all-ones.
- **`conf` change.** A change takes effect the same cycle. Words already in the FIFO are unaffected.

## Timing
- Reset (async assert, sync release):
  - `cnt=0`, `ptr=0`, counters 0.
  - `BD_out.v=0`; all `a=0` (the global discard path is also off during reset).
  - FIFO contents are don't-care.
- **Latency.** Accept in cycle N gives `BD_out.v=1` in cycle N+1.
- **Throughput.** 1 word/cycle sustained with `BD_out.a` held high.
- **Backpressure.** With `BD_out.a=0`, two words are accepted, then all merge-path `a=0`. Discard-path acks continue.
- **Reset mid-operation.** Buffered words are lost and no partial word is emitted.

## Structure
- Package `BDTagMergePkg`:
  - leaf code constant `INPUT_TAGS_code`;
  - source index enum {SRC_OTHER, SRC_TAG, SRC_GLOBAL};
  - word struct {payload, leaf_code}.
- Sub-module `bd_word_fifo2`: 2-entry valid/ack FIFO with async active-low reset, push-if-not-full, registered head. The arbiter, encoding and counters live in the top level.

## Test plan
- Single `tag_in` word (tag=0x155, ct=0x0A) → next cycle `BD_out` payload=0x0000_2AA0A, leaf=2; `tags_merged`=1.
- All three sources held valid, `BD_out.a=1` → output order other, tag, global, other…; one word per cycle; `ptr` cycles 1,2,0.
- `global_en=1`, `global_tag_in` gt=0x7FF, tag=0x001, ct=0x003 → payload=0x203, leaf=2; global field zero.
- `global_en=0`, 5 global words → all acked back-to-back, none on `BD_out`, `globals_dropped`=5.
- `BD_out.a=0`, `other_in` streaming → exactly 2 accepted, then `a=0`; raise `BD_out.a` → both drain in order, then the stream resumes at 1/cycle.
- Assert reset with `cnt=2` → `BD_out.v=0` immediately; after release, counters 0 and the first grant goes to other.
